// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: opcodes, FSM states,
// halt causes and the instruction classes produced by the opcode classifier.
package rv32i_ctrl_pkg;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ECALL   = 2'd1,
        CAUSE_ILLEGAL = 2'd2,
        CAUSE_TIMEOUT = 2'd3
    } halt_cause_t;

    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_I_ALU   = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_FENCE   = 4'd9,
        CLS_SYSTEM  = 4'd10,
        CLS_ILLEGAL = 4'd11
    } instr_class_t;

endpackage

// File: rtl/rv32i_opcode_classifier.sv
// Combinational decode of the IR into an instruction class, an illegal flag and
// whether the instruction writes a non-zero destination register.
module rv32i_opcode_classifier
    import rv32i_ctrl_pkg::*;
(
    input  logic [31:0]  ir,
    output instr_class_t cls,
    output logic         illegal,
    output logic         writes_rd
);

    // Only ECALL/EBREAK (funct3 = 000) are accepted from the SYSTEM space.
    always_comb begin
        cls = CLS_ILLEGAL;
        case (ir[6:0])
            OPC_OP:       cls = CLS_R;
            OPC_OP_IMM:   cls = CLS_I_ALU;
            OPC_LOAD:     cls = CLS_LOAD;
            OPC_STORE:    cls = CLS_STORE;
            OPC_BRANCH:   cls = CLS_BRANCH;
            OPC_JAL:      cls = CLS_JAL;
            OPC_JALR:     cls = CLS_JALR;
            OPC_LUI:      cls = CLS_LUI;
            OPC_AUIPC:    cls = CLS_AUIPC;
            OPC_MISC_MEM: cls = CLS_FENCE;
            OPC_SYSTEM:   cls = (ir[14:12] == 3'b000) ? CLS_SYSTEM : CLS_ILLEGAL;
            default:      cls = CLS_ILLEGAL;
        endcase
    end

    assign illegal = (cls == CLS_ILLEGAL);

    // Destination-writing classes, suppressed when rd is x0.
    always_comb begin
        writes_rd = 1'b0;
        case (cls)
            CLS_R, CLS_I_ALU, CLS_LOAD, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC:
                writes_rd = (ir[11:7] != 5'd0);
            default:
                writes_rd = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32i_multicycle_controller.sv
// Multi-cycle RV32I sequencer: IF -> ID -> EX -> (MEM) -> WB with memory
// handshakes, ready timeouts, sticky halt and a retired-instruction counter.
module rv32i_multicycle_controller
    import rv32i_ctrl_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      ir,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             if_en,
    output logic             id_en,
    output logic             ex_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pc_we,
    output logic             rf_we,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);

    localparam int            WW        = $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

    state_t         state_r, state_next_s;
    halt_cause_t    cause_r, cause_next_s;
    logic [WW-1:0]  wait_cnt_r;
    logic [CNT_W-1:0] instret_r;
    instr_class_t   cls_s;
    logic           illegal_s, writes_rd_s;

    rv32i_opcode_classifier u_classifier (
        .ir        (ir),
        .cls       (cls_s),
        .illegal   (illegal_s),
        .writes_rd (writes_rd_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and halt-cause selection.
    always_comb begin
        state_next_s = state_r;
        cause_next_s = CAUSE_NONE;
        case (state_r)
            ST_IDLE:      state_next_s = start ? ST_FETCH : ST_IDLE;
            ST_FETCH: begin
                if (imem_ready) begin
                    state_next_s = ST_DECODE;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_next_s = ST_HALT;
                    cause_next_s = CAUSE_TIMEOUT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (illegal_s) begin
                    state_next_s = ST_HALT;
                    cause_next_s = CAUSE_ILLEGAL;
                end else if (cls_s == CLS_SYSTEM) begin
                    state_next_s = ST_HALT;
                    cause_next_s = CAUSE_ECALL;
                end else begin
                    state_next_s = ST_EXECUTE;
                end
            end
            ST_EXECUTE:   state_next_s = (cls_s == CLS_LOAD || cls_s == CLS_STORE)
                                         ? ST_MEMORY : ST_WRITEBACK;
            ST_MEMORY: begin
                if (dmem_ready) begin
                    state_next_s = ST_WRITEBACK;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_next_s = ST_HALT;
                    cause_next_s = CAUSE_TIMEOUT;
                end else begin
                    state_next_s = ST_MEMORY;
                end
            end
            ST_WRITEBACK: state_next_s = ST_FETCH;
            ST_HALT:      state_next_s = ST_HALT;
            default:      state_next_s = ST_IDLE;
        endcase
    end

    // Wait counter, halt cause capture and retired-instruction count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt_r <= '0;
            cause_r    <= CAUSE_NONE;
            instret_r  <= '0;
        end else begin
            if ((state_r == ST_FETCH || state_r == ST_MEMORY) && state_next_s == state_r) begin
                wait_cnt_r <= wait_cnt_r + WW'(1);
            end else begin
                wait_cnt_r <= '0;
            end
            if (state_r != ST_HALT && state_next_s == ST_HALT) begin
                cause_r <= cause_next_s;
            end else begin
                cause_r <= cause_r;
            end
            if (state_r == ST_WRITEBACK) begin
                instret_r <= instret_r + CNT_W'(1);
            end else begin
                instret_r <= instret_r;
            end
        end
    end

    // Enables and requests; fetch and memory strobes follow ready in the same cycle.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        if_en    = 1'b0;
        id_en    = 1'b0;
        ex_en    = 1'b0;
        mem_en   = 1'b0;
        wb_en    = 1'b0;
        pc_we    = 1'b0;
        rf_we    = 1'b0;
        halted   = 1'b0;
        case (state_r)
            ST_FETCH: begin
                imem_req = 1'b1;
                if_en    = imem_ready;
            end
            ST_DECODE:  id_en = 1'b1;
            ST_EXECUTE: ex_en = 1'b1;
            ST_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_s == CLS_STORE);
                mem_en   = dmem_ready;
            end
            ST_WRITEBACK: begin
                wb_en = 1'b1;
                pc_we = 1'b1;
                rf_we = writes_rd_s;
            end
            ST_HALT:  halted = 1'b1;
            default:  halted = 1'b0;
        endcase
    end

    assign halt_cause = cause_r;
    assign instret    = instret_r;
    assign state      = state_r;

endmodule

// File: doc/rv32i_multicycle_controller.md
Name: rv32i_multicycle_controller

Overview:
FSM that sequences the RV32I datapath as a multi-cycle machine: IF -> ID -> EX -> (MEM) -> WB, one instruction at a time.
- Drives one-cycle enables that latch the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Handshakes with instruction and data memory, gates register-file and PC writes, and counts retired instructions.
- Halts on ECALL/EBREAK, an illegal opcode, or a memory timeout.

Parameters:
CNT_W, 32, width of the retired-instruction counter
WAIT_MAX, 255, maximum cycles to wait for imem_ready/dmem_ready before a timeout halt

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
start  in  1  begins execution from IDLE
ir  in  32  current instruction (IF/ID IR contents)
imem_req  out  1  instruction fetch request
imem_ready  in  1  instruction read data valid
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
dmem_ready  in  1  data access complete
if_en  out  1  latch IF/ID register
id_en  out  1  latch ID/EX register
ex_en  out  1  latch EX/MEM register
mem_en  out  1  latch MEM/WB register
wb_en  out  1  writeback strobe
pc_we  out  1  load PC_NEXT into PC
rf_we  out  1  register-file write enable
halted  out  1  sticky halt flag
halt_cause  out  2  0 none, 1 ecall/ebreak, 2 illegal, 3 timeout
instret  out  CNT_W  retired-instruction count
state  out  3  current FSM state (debug)

Behaviour:
- Reset: rst=0 sampled at a rising edge -> state=IDLE, all outputs 0, instret=0, wait counter=0. Applies mid-instruction too; no partial writeback.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
- IDLE: start=1 -> FETCH. start is ignored in every other state.
- FETCH: imem_req=1 while in state.
  - imem_ready=1 -> if_en=1 in that same cycle (Mealy), then DECODE.
- DECODE: id_en=1 for one cycle. Classify ir[6:0]:
  - 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0001111 (FENCE = NOP) -> EXECUTE.
  - 1110011 with ir[14:12]=000 -> HALT, cause 1.
  - Anything else, including other SYSTEM funct3 -> HALT, cause 2.
- EXECUTE: ex_en=1 for one cycle. LOAD/STORE -> MEMORY; otherwise -> WRITEBACK.
- MEMORY: dmem_req=1 while in state; dmem_we=1 only for STORE.
  - dmem_ready=1 -> mem_en=1 in that same cycle, then WRITEBACK.
- WRITEBACK: wb_en=1 and pc_we=1 for one cycle.
  - rf_we=1 iff class is R, I-ALU, LOAD, JAL, JALR, LUI or AUIPC, and ir[11:7]!=0.
  - instret += 1, wrapping modulo 2^CNT_W.
  - -> FETCH.
- Timeout: wait counter clears on entry to FETCH/MEMORY and increments each cycle ready=0. If it reaches WAIT_MAX with ready still 0 -> HALT, cause 3, request dropped next cycle. Ready arriving on exactly the WAIT_MAX cycle counts as success.
- HALT: halted=1, all enables and requests 0, halt_cause held. Only reset exits.
- ir must stay stable from DECODE through WRITEBACK. The controller samples it combinationally in each of those states and does not re-register it.
- imem_ready outside FETCH and dmem_ready outside MEMORY are ignored.
- At most one of if_en/id_en/ex_en/mem_en/wb_en is high in any cycle.
- Latency with zero-wait memory: ALU/branch/jump instructions 4 cycles (IF, ID, EX, WB); load/store 5 cycles.

Decomposition:
- Package rv32i_ctrl_pkg: opcode constants, state encoding, halt_cause codes, instruction-class enum.
- One combinational sub-module, rv32i_opcode_classifier: ir -> class, illegal flag, writes_rd.

Test Plan:
1. Reset with rst=0 for 2 cycles, then rst=1, start=1, imem_ready=1, ir=0x003100B3 (ADD x1,x2,x3) -> state sequence FETCH, DECODE, EXECUTE, WRITEBACK; rf_we=1 only in WRITEBACK; instret=1 after 4 cycles; no dmem_req.
2. ir=0x0000A283 (LW x5,0(x1)), dmem_ready held 0 for 3 cycles then 1 -> dmem_req high 4 cycles, dmem_we=0, mem_en pulses with ready, rf_we=1, 8 cycles total.
3. ir=0x0050A223 (SW x5,4(x1)), dmem_ready=1 -> dmem_we=1 for 1 cycle, rf_we=0 in WRITEBACK, pc_we=1; ir=0x00000013 (ADDI x0,x0,0) -> rf_we=0, instret still increments.
4. ir=0x00000073 (ECALL) -> HALT after DECODE, halted=1, halt_cause=1, instret unchanged; ir=0xFFFFFFFF -> halt_cause=2. Further start/imem_ready pulses change nothing.
5. WAIT_MAX=4, imem_ready stuck 0 -> halted with halt_cause=3 exactly 4 cycles after FETCH entry. Repeat with ready on cycle 4 -> no halt, DECODE follows.
6. rst=0 asserted in MEMORY with dmem_req=1 -> next cycle state=IDLE, all outputs 0, instret=0. CNT_W=4 with 16 NOPs -> instret wraps to 0.
